// File: rtl/rx_queue_pkg.sv
// rx_queue_pkg: shared network parameters and helpers for the receiver and its queue
package rx_queue_pkg;
  localparam int net_width = 32;
  localparam int queue_depth = 8;
  localparam logic [7:0] drop_max = 8'hff;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == drop_max ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/rx_queue_if.sv
// rx_queue_if: producer/consumer handshake and status bundle of the receive queue
interface rx_queue_if import rx_queue_pkg::*; #(
  parameter int width = net_width,
  parameter int depth = queue_depth
);
  logic wr_en;
  logic [width-1:0] wr_data;
  logic out_valid;
  logic [width-1:0] out_data;
  logic out_ready;
  logic full;
  logic [$clog2(depth):0] count;
  logic overflow;
  logic [7:0] drop_cnt;
  logic clear_ovf;
  modport master (
    output wr_en, wr_data, out_ready, clear_ovf,
    input out_valid, out_data, full, count, overflow, drop_cnt
  );
  modport slave (
    input wr_en, wr_data, out_ready, clear_ovf,
    output out_valid, out_data, full, count, overflow, drop_cnt
  );
endinterface

// File: rtl/rx_queue_mem.sv
// queue_mem: depth x width register array, synchronous write, combinational read
module queue_mem #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input logic clk,
  input logic we,
  input logic [$clog2(depth)-1:0] waddr,
  input logic [width-1:0] wdata,
  input logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem [depth];
  // storage is never reset; only the pointers decide what is valid
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rx_queue.sv
// rx_queue: first-word-fall-through receive queue with sticky overflow and drop counter
module rx_queue import rx_queue_pkg::*; #(
  parameter int width = net_width,
  parameter int depth = queue_depth
) (
  input logic clk,
  input logic reset,
  rx_queue_if.slave q
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] cnt;
  logic overflow;
  logic [7:0] drop_cnt;
  logic valid, full, push, pop, drop;
  logic [width-1:0] rd_data;
  assign valid = cnt != '0;
  assign full = cnt == cw'(depth);
  assign pop = valid & q.out_ready;
  assign push = q.wr_en & (~full | pop);
  assign drop = q.wr_en & ~push;
  queue_mem #(.width(width), .depth(depth)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(q.wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  // pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + cw'(push) - cw'(pop);
    end
  // a drop in the same cycle as a clear wins and restarts the count at one
  always_ff @(posedge clk)
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= q.clear_ovf ? 8'd1 : sat_inc(drop_cnt);
    end else if (q.clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  assign q.out_valid = valid;
  assign q.out_data = valid ? rd_data : '0;
  assign q.full = full;
  assign q.count = cnt;
  assign q.overflow = overflow;
  assign q.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_rx_queue.sv
// tb_rx_queue: randomized and directed check of rx_queue against a queue-based reference
module tb_rx_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] mdl [$];
  bit m_ovf = 1'b0;
  int m_drop = 0;
  always #5 clk = ~clk;
  rx_queue_if #(.width(32), .depth(8)) q ();
  rx_queue #(.width(32), .depth(8)) dut (.clk(clk), .reset(reset), .q(q));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cyc(input logic we, input logic [31:0] wd, input logic rdy, input logic clr, input logic rs = 1'b0);
    bit p, w;
    q.wr_en = we;
    q.wr_data = wd;
    q.out_ready = rdy;
    q.clear_ovf = clr;
    reset = rs;
    @(negedge clk);
    check("valid", 32'(q.out_valid), 32'(mdl.size() != 0));
    check("data", q.out_data, mdl.size() != 0 ? mdl[0] : 32'd0);
    check("count", 32'(q.count), 32'(mdl.size()));
    check("full", 32'(q.full), 32'(mdl.size() == 8));
    check("overflow", 32'(q.overflow), 32'(m_ovf));
    check("drop_cnt", 32'(q.drop_cnt), 32'(m_drop));
    if (rs) begin
      mdl.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      p = rdy && mdl.size() != 0;
      w = we && (mdl.size() < 8 || p);
      if (p) void'(mdl.pop_front());
      if (w) mdl.push_back(wd);
      if (we && !w) begin
        m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
        m_ovf = 1'b1;
      end else if (clr) begin
        m_drop = 0;
        m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1'b1, 32'(base + i), 1'b0, 1'b0);
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask
  initial begin
    q.wr_en = 1'b0;
    q.wr_data = '0;
    q.out_ready = 1'b0;
    q.clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    check("first_word", q.out_data, 32'hA5A5_0001);
    drain(2);
    fill(8, 1);
    check("full_8", 32'(q.full), 32'd1);
    cyc(1'b1, 32'h9, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    check("drop_one", 32'(q.drop_cnt), 32'd1);
    drain(9);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    fill(8, 1);
    cyc(1'b1, 32'h9, 1'b1, 1'b0);
    check("full_pop_push", 32'(q.count), 32'd8);
    drain(9);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'(100 + i), 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
    end
    fill(8, 200);
    for (int i = 0; i < 300; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    check("drop_sat", 32'(q.drop_cnt), 32'd255);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("clear", 32'(q.drop_cnt), 32'd0);
    cyc(1'b1, 32'd1, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    check("drop_over_clear", 32'(q.drop_cnt), 32'd1);
    cyc(1'b1, 32'd5, 1'b1, 1'b1, 1'b1);
    fill(5, 300);
    cyc(1'b1, 32'd6, 1'b1, 1'b1, 1'b1);
    check("reset_count", 32'(q.count), 32'd0);
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    check("post_reset", q.out_data, 32'h7);
    for (int b = 0; b < 16; b++) begin
      int pw = $urandom_range(10, 90);
      int pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++)
        cyc($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
            $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_queue.md
RX_QUEUE -- requirements
Module: rx_queue

Interface
REQ-001 Parameter: width, 32, bit width of one received network word.
REQ-002 Parameter: depth, 8, number of queue entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: wr_en  input  1  write strobe; driven by the receiver's sig_alert edge pulse.
REQ-006 Port: wr_data  input  width  word to enqueue; driven by the receiver's processed_sig.
REQ-007 Port: out_valid  output  1  head entry present (queue not empty).
REQ-008 Port: out_data  output  width  head entry; first-word-fall-through.
REQ-009 Port: out_ready  input  1  consumer accepts head this cycle.
REQ-010 Port: full  output  1  count equals depth.
REQ-011 Port: count  output  clog2(depth)+1  number of stored entries.
REQ-012 Port: overflow  output  1  sticky flag, a write was dropped.
REQ-013 Port: drop_cnt  output  8  saturating count of dropped writes.
REQ-014 Port: clear_ovf  input  1  clears overflow and drop_cnt.

Function
REQ-015 Push occurs when wr_en=1 and (full=0 or pop occurs in the same cycle).
REQ-016 Pop occurs when out_valid=1 and out_ready=1.
REQ-017 Push writes wr_data at wr_ptr and increments wr_ptr modulo depth.
REQ-018 Pop increments rd_ptr modulo depth; pointers wrap from depth-1 to 0.
REQ-019 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 out_valid = (count != 0); out_data = mem[rd_ptr] when valid, else all zeros.
REQ-021 Latency: word pushed in cycle N appears on out_data/out_valid in cycle N+1 if queue was empty.
REQ-022 Empty queue: simultaneous wr_en and out_ready performs push only, with no pop.
REQ-023 Full queue with pop in same cycle: push is accepted, count stays depth, FIFO order preserved.
REQ-024 Drop: wr_en=1, full=1, no pop -> word discarded, overflow set next cycle, drop_cnt +1 saturating at 255.
REQ-025 clear_ovf=1 zeroes overflow and drop_cnt next cycle; a simultaneous drop takes priority (overflow=1, drop_cnt=1).
REQ-026 out_ready while empty has no effect.
REQ-027 wr_en is sampled every cycle; back-to-back pulses each push one word.

Reset
REQ-028 reset=1 at a clock edge sets wr_ptr, rd_ptr, and count to 0, overflow to 0, and drop_cnt to 0; out_valid=0 and out_data=0 the following cycle.
REQ-029 Reset takes priority over push, pop, and clear_ovf in the same cycle; storage contents are not reset.
REQ-030 Reset mid-stream discards all stored entries; the first post-reset push lands in entry 0.

Structure
REQ-031 Network word width and default queue depth are defined once in the shared network parameter header used by receiver and queue.
REQ-032 Storage is one sub-module, queue_mem: depth x width register array with synchronous write and combinational read.
REQ-033 Pointers, count, and flags live in rx_queue; no latches and no combinational path from wr_en to out_data.

Verification
REQ-034 Reset, then push 0xA5A5_0001 -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1.
REQ-035 Push 8 words 1..8 with out_ready=0 -> full=1, count=8; 9th push 0x9 -> overflow=1, drop_cnt=1; drain yields 1..8 in order.
REQ-036 Full queue, wr_en=1 with 0x9 and out_ready=1 same cycle -> count stays 8, pops 1, tail is 0x9.
REQ-037 20 push/pop cycles alternating -> pointers wrap twice and output order matches input order.
REQ-038 300 drops while full -> drop_cnt=255; then clear_ovf -> overflow=0, drop_cnt=0.
REQ-039 Reset asserted with count=5 -> next cycle count=0, out_valid=0; push 0x7 -> out_data=0x7.
